// File: rtl/rx_packet_ctrl.sv
// Command-frame receiver behind a UART byte stream: SYNC, OPCODE, LEN, DATA[], CHK.
// Validated frames are held on a valid/ready output; protocol faults raise a one-cycle error pulse.
module rx_packet_ctrl #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          MAX_LEN      = 8
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst,
    input  logic                   i_RX_DV,
    input  logic [7:0]             i_RX_Byte,
    output logic                   o_Cmd_Valid,
    input  logic                   i_Cmd_Ready,
    output logic [7:0]             o_Cmd_Opcode,
    output logic [3:0]             o_Cmd_Len,
    output logic [8*MAX_LEN-1:0]   o_Cmd_Data,
    output logic                   o_Err,
    output logic [1:0]             o_Err_Code,
    output logic                   o_Busy,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPCODE = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    localparam int              TO_LIMIT  = 20 * CLKS_PER_BIT;
    localparam int              TCW       = $clog2(TO_LIMIT);
    localparam logic [TCW-1:0]  TO_LAST   = TCW'(TO_LIMIT - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN  = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd3;

    state_t               state;
    state_t               state_next;
    logic [TCW-1:0]       tcnt;
    logic [7:0]           opcode_q;
    logic [3:0]           len_q;
    logic [3:0]           idx_q;
    logic [7:0]           sum_q;
    logic [8*MAX_LEN-1:0] data_q;
    logic                 err_q;
    logic [1:0]           err_code_q;
    logic                 err_next;
    logic [1:0]           code_next;
    logic                 timed;
    logic                 timeout_hit;

    // Handshake: the command transfers on any cycle where o_Cmd_Valid and i_Cmd_Ready
    // are both high; until then valid stays high and opcode/len/data do not change.
    assign o_Cmd_Valid  = (state == S_HOLD);
    assign o_Busy       = (state != S_IDLE);
    assign o_Cmd_Opcode = opcode_q;
    assign o_Cmd_Len    = len_q;
    assign o_Cmd_Data   = data_q;
    assign o_Err        = err_q;
    assign o_Err_Code   = err_code_q;
    assign dbg_state    = state;

    assign timed       = (state == S_OPCODE) || (state == S_LEN) ||
                         (state == S_DATA)   || (state == S_CHK);
    assign timeout_hit = timed && !i_RX_DV && (tcnt == TO_LAST);

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        code_next  = 2'd0;
        case (state)
            S_IDLE: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    state_next = S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (i_RX_DV) begin
                    state_next = S_LEN;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                end
            end
            S_LEN: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte > MAX_LEN_B) begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                        code_next  = ERR_BAD_LEN;
                    end else if (i_RX_Byte == 8'd0) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                end
            end
            S_DATA: begin
                if (i_RX_DV) begin
                    if (idx_q == (len_q - 4'd1)) begin
                        state_next = S_CHK;
                    end
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                end
            end
            S_CHK: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == sum_q) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                        code_next  = ERR_CHECKSUM;
                    end
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                end
            end
            S_HOLD: begin
                // A byte arriving in the transfer cycle is treated as the first IDLE byte.
                if (i_Cmd_Ready) begin
                    if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                        state_next = S_OPCODE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (i_RX_DV) begin
                    err_next  = 1'b1;
                    code_next = ERR_OVERRUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            tcnt       <= '0;
            opcode_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            err_q      <= err_next;
            err_code_q <= code_next;
            // Restarts on every byte and on every state change, including timeout exit.
            if (timed && !i_RX_DV && (state_next == state)) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
            case (state)
                S_OPCODE: begin
                    if (i_RX_DV) begin
                        opcode_q <= i_RX_Byte;
                        sum_q    <= i_RX_Byte;
                    end
                end
                S_LEN: begin
                    if (i_RX_DV && (i_RX_Byte <= MAX_LEN_B)) begin
                        len_q <= i_RX_Byte[3:0];
                        sum_q <= sum_q + i_RX_Byte;
                        idx_q <= 4'd0;
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (8'(k) >= i_RX_Byte) begin
                                data_q[8*k +: 8] <= 8'd0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (i_RX_DV) begin
                        data_q[8*int'(idx_q) +: 8] <= i_RX_Byte;
                        sum_q <= sum_q + i_RX_Byte;
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl: directed frames plus randomized frames whose
// expected commands and errors come from a frame-level reference model.
module tb_rx_packet_ctrl;

  localparam int         CPB  = 2;
  localparam int         ML   = 8;
  localparam int         TO   = 20 * CPB;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_ready;
  logic        man_ready = 1'b0;
  logic        auto_ready = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [75:0] cmd_q[$];
  logic [1:0]  err_q[$];

  logic        prev_hold = 1'b0;
  logic [76:0] prev_snap = '0;

  assign cmd_ready = auto_ready ? rnd_ready : man_ready;

  // clock / reset
  always #5 clk = ~clk;

  rx_packet_ctrl #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(SYNC),
    .MAX_LEN(ML)
  ) dut (
    .i_Clock(clk),
    .i_Rst(rst),
    .i_RX_DV(rx_dv),
    .i_RX_Byte(rx_byte),
    .o_Cmd_Valid(cmd_valid),
    .i_Cmd_Ready(cmd_ready),
    .o_Cmd_Opcode(cmd_opcode),
    .o_Cmd_Len(cmd_len),
    .o_Cmd_Data(cmd_data),
    .o_Err(err),
    .o_Err_Code(err_code),
    .o_Busy(busy),
    .dbg_state(dbg_state)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (err) begin
        if (err_q.size() == 0) flag_fail("unexpected_err");
        else check("err_code", 80'(err_code), 80'(err_q.pop_front()));
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) flag_fail("unexpected_cmd");
        else check("cmd", 80'({cmd_opcode, cmd_len, cmd_data}), 80'(cmd_q.pop_front()));
      end
      if (prev_hold) begin
        check("hold_stable", 80'({cmd_valid, cmd_opcode, cmd_len, cmd_data}), 80'(prev_snap));
      end
      prev_hold = cmd_valid && !cmd_ready;
      prev_snap = {1'b1, cmd_opcode, cmd_len, cmd_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    rx_byte = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_list(input bytes_t bq, input int maxgap);
    foreach (bq[i]) send_byte(bq[i], $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 80'(busy), 80'(0));
  endtask

  function automatic logic [75:0] model_cmd(input logic [7:0] op, input bytes_t payload);
    logic [63:0] d = '0;
    foreach (payload[k]) d[8*k +: 8] = payload[k];
    return {op, 4'(payload.size()), d};
  endfunction

  function automatic logic [7:0] model_sum(input bytes_t bq);
    logic [7:0] s = 8'd0;
    foreach (bq[i]) s = s + bq[i];
    return s;
  endfunction

  // kind 0 good, 1 bad checksum, 2 bad length, 3 truncated (timeout)
  task automatic random_frame();
    int         kind;
    int         len;
    int         keep;
    logic [7:0] op;
    logic [7:0] jb;
    bytes_t     junk;
    bytes_t     payload;
    bytes_t     body;
    bytes_t     all;
    kind = $urandom_range(0, 3);
    op   = 8'($urandom);
    len  = $urandom_range(0, ML);
    repeat ($urandom_range(0, 2)) begin
      do jb = 8'($urandom); while (jb == SYNC);
      junk.push_back(jb);
    end
    body.push_back(SYNC);
    body.push_back(op);
    if (kind == 2) begin
      body.push_back(8'($urandom_range(ML + 1, 255)));
      err_q.push_back(2'd3);
    end else begin
      body.push_back(8'(len));
      for (int k = 0; k < len; k++) payload.push_back(8'($urandom));
      foreach (payload[k]) body.push_back(payload[k]);
      if (kind == 1) body.push_back(model_sum(body[1:$]) + 8'($urandom_range(1, 255)));
      else body.push_back(model_sum(body[1:$]));
      if (kind == 0) cmd_q.push_back(model_cmd(op, payload));
      if (kind == 1) err_q.push_back(2'd1);
      if (kind == 3) begin
        err_q.push_back(2'd2);
        keep = $urandom_range(1, body.size() - 1);
        while (body.size() > keep) void'(body.pop_back());
      end
    end
    all = {junk, body};
    send_list(all, 3);
    wait_idle("frame_idle", TO + 60);
  endtask

  initial begin
    int n;
    bytes_t p;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_busy", 80'({cmd_valid, busy}), 80'(0));
    check("rst_err", 80'({err, err_code}), 80'(0));
    check("rst_cmd", 80'({cmd_opcode, cmd_len, cmd_data}), 80'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // held command survives 5 cycles of ready=0, clears one cycle after ready
    p = {8'h33, 8'h44};
    cmd_q.push_back(model_cmd(8'h10, p));
    send_list({SYNC, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89}, 0);
    check("hold_valid", 80'(cmd_valid), 80'(1));
    check("hold_fields", 80'({cmd_opcode, cmd_len, cmd_data}), 80'({8'h10, 4'd2, 64'h4433}));
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_wait", 80'(cmd_valid), 80'(1));
    end
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    check("after_xfer", 80'({cmd_valid, busy}), 80'(0));

    // zero length, bad checksum, bad length then recovery
    auto_ready = 1'b1;
    p = {};
    cmd_q.push_back(model_cmd(8'h20, p));
    send_list({SYNC, 8'h20, 8'h00, 8'h20}, 1);
    wait_idle("len0_idle", 50);
    err_q.push_back(2'd1);
    send_list({SYNC, 8'h10, 8'h02, 8'h33, 8'h44, 8'h88}, 1);
    wait_idle("badchk_idle", 50);
    err_q.push_back(2'd3);
    send_list({SYNC, 8'h01, 8'h09}, 0);
    check("badlen_idle", 80'(busy), 80'(0));
    cmd_q.push_back(model_cmd(8'h05, p));
    send_list({SYNC, 8'h05, 8'h00, 8'h05}, 0);
    wait_idle("recover_idle", 50);

    // timeout latency from the opcode strobe
    err_q.push_back(2'd2);
    send_list({SYNC, 8'h10}, 0);
    n = 0;
    while (!err && n < TO + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_latency", 80'(n), 80'(TO));
    @(posedge clk);
    #1;
    check("timeout_busy", 80'({busy, err}), 80'(0));

    // overrun in HOLD, then SYNC coincident with transfer
    auto_ready = 1'b0;
    p = {8'h5A};
    cmd_q.push_back(model_cmd(8'h33, p));
    send_list({SYNC, 8'h33, 8'h01, 8'h5A, 8'h8E}, 0);
    check("ovr_hold", 80'(cmd_valid), 80'(1));
    err_q.push_back(2'd0);
    send_byte(8'h77, 0);
    check("ovr_err", 80'({err, err_code}), 80'({1'b1, 2'd0}));
    check("ovr_kept", 80'({cmd_valid, cmd_opcode, cmd_len, cmd_data}), 80'({1'b1, 8'h33, 4'd1, 64'h5A}));
    rx_dv = 1'b1;
    rx_byte = SYNC;
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    man_ready = 1'b0;
    check("coincident_sync", 80'({busy, cmd_valid}), 80'({1'b1, 1'b0}));
    p = {};
    cmd_q.push_back(model_cmd(8'h05, p));
    auto_ready = 1'b1;
    send_list({8'h05, 8'h00, 8'h05}, 0);
    wait_idle("coincident_idle", 50);

    // asynchronous reset mid-frame
    send_list({SYNC, 8'h10, 8'h02, 8'h33}, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out", 80'({cmd_valid, busy, err, err_code, cmd_opcode, cmd_len}), 80'(0));
    check("midrst_data", 80'(cmd_data), 80'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_list({8'h44, 8'h89}, 0);
    check("midrst_nosync", 80'(busy), 80'(0));
    p = {8'h33, 8'h44};
    cmd_q.push_back(model_cmd(8'h10, p));
    send_list({SYNC, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89}, 2);
    wait_idle("midrst_frame_idle", 50);

    // randomized frames
    for (int i = 0; i < 60; i++) random_frame();

    repeat (5) @(posedge clk);
    #1;
    check("cmd_q_drained", 80'(cmd_q.size()), 80'(0));
    check("err_q_drained", 80'(err_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_packet_ctrl.md
RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clocks per UART bit; sets the timeout length.
REQ-002 Parameter: SYNC_BYTE, 8'hA5, frame start marker.
REQ-003 Parameter: MAX_LEN, 8, maximum payload bytes; the block SHALL support only 1..8.
REQ-004 i_Clock  in  1  single clock; all logic SHALL be posedge i_Clock.
REQ-005 i_Rst  in  1  asynchronous, active-high reset.
REQ-006 i_RX_DV  in  1  one-cycle strobe from the UART receiver: byte valid.
REQ-007 i_RX_Byte  in  8  received byte; valid only when i_RX_DV=1.
REQ-008 o_Cmd_Valid  out  1  decoded command available.
REQ-009 i_Cmd_Ready  in  1  consumer accepts the command.
REQ-010 o_Cmd_Opcode  out  8  command opcode.
REQ-011 o_Cmd_Len  out  4  payload byte count, 0..MAX_LEN.
REQ-012 o_Cmd_Data  out  8*MAX_LEN  payload; byte k at [8k+7:8k]; unused bytes are 0.
REQ-013 o_Err  out  1  one-cycle error pulse.
REQ-014 o_Err_Code  out  2  error cause, valid with o_Err: 0 overrun, 1 checksum, 2 timeout, 3 bad length.
REQ-015 o_Busy  out  1  high in any state other than IDLE.

Function
REQ-016 Frame format SHALL be: SYNC_BYTE, OPCODE, LEN, DATA[0..LEN-1], CHK, where CHK = (OPCODE+LEN+ΣDATA) mod 256.
REQ-017 States SHALL be IDLE, OPCODE, LEN, DATA, CHK and HOLD; the controller SHALL act only on cycles with i_RX_DV=1, except for the timeout and the handshake.
REQ-018 IDLE: a byte equal to SYNC_BYTE SHALL go to OPCODE; any other byte SHALL be discarded silently.
REQ-019 OPCODE: the byte SHALL be latched as the opcode, the running sum SHALL be set to it, and the state SHALL go to LEN.
REQ-020 LEN: if LEN>MAX_LEN, the block SHALL pulse o_Err with code 3 and go to IDLE.
REQ-021 LEN: if LEN=0, the state SHALL go to CHK; otherwise it SHALL go to DATA with byte index 0.
REQ-022 LEN: the running sum SHALL be updated with the LEN byte in both valid cases.
REQ-023 DATA: each byte SHALL be stored at the current index and added to the running sum with 8-bit wrap; after byte LEN-1 the state SHALL go to CHK.
REQ-024 Payload bytes at or above LEN SHALL be cleared to 0 when the LEN byte is accepted.
REQ-025 CHK: on match, the state SHALL go to HOLD with o_Cmd_Valid=1 on the next cycle.
REQ-026 CHK: on mismatch, the block SHALL pulse o_Err with code 1, discard the frame, and go to IDLE.
REQ-027 Timeout: in OPCODE, LEN, DATA and CHK, a counter SHALL clear on every accepted byte and on state entry.
REQ-028 Timeout: when the counter reaches 20*CLKS_PER_BIT-1 with no byte, the block SHALL pulse o_Err with code 2 and go to IDLE; the counter width SHALL be $clog2(20*CLKS_PER_BIT).
REQ-029 HOLD: o_Cmd_Valid SHALL stay high and o_Cmd_Opcode, o_Cmd_Len and o_Cmd_Data SHALL stay stable until o_Cmd_Valid & i_Cmd_Ready.
REQ-030 HOLD: on transfer, o_Cmd_Valid SHALL drop on the next edge and the state SHALL go to IDLE.
REQ-031 HOLD: an i_RX_DV with no transfer in the same cycle SHALL drop the byte and pulse o_Err with code 0.
REQ-032 HOLD: an i_RX_DV in the same cycle as a transfer SHALL be handled as an IDLE byte, so SYNC_BYTE goes directly to OPCODE.
REQ-033 i_Cmd_Ready outside HOLD SHALL be ignored.
REQ-034 Errors in a single cycle SHALL be mutually exclusive; o_Err SHALL never be high for two consecutive cycles from one event.

Reset
REQ-035 While i_Rst=1, the block SHALL force IDLE and o_Cmd_Valid=0, o_Err=0, o_Err_Code=0, o_Busy=0, o_Cmd_Opcode=0, o_Cmd_Len=0, o_Cmd_Data=0, and clear the timeout counter, byte index and running sum, regardless of the clock.
REQ-036 Reset asserted mid-frame or in HOLD SHALL abandon the frame with no o_Err pulse; after release, the block SHALL need a new SYNC_BYTE.

Verification
REQ-037 Bytes A5 10 02 33 44 89 -> o_Cmd_Valid=1 with opcode 10, len 2, data[15:0]=4433, upper bytes 0; it stays high through 5 cycles of i_Cmd_Ready=0, then clears one cycle after ready.
REQ-038 Bytes A5 20 00 20 -> valid command, opcode 20, len 0, data all 0; bytes A5 10 02 33 44 88 -> o_Err with code 1, no valid.
REQ-039 Bytes A5 01 09 -> o_Err with code 3; a following A5 05 00 05 -> valid command, opcode 05.
REQ-040 Bytes A5 10 then silence -> o_Err with code 2 exactly 20*CLKS_PER_BIT clocks after the 10 strobe; o_Busy=0 afterwards.
REQ-041 A valid frame held in HOLD, then byte 77 with ready=0 -> o_Err with code 0 and the held command unchanged; byte A5 coincident with ready=1 -> transfer and o_Busy=1 (OPCODE).
REQ-042 i_Rst pulsed after A5 10 02 33 -> all outputs 0 and no error; then a full valid frame -> correct command.
